// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready request and
// response channels, with WAIT_CYCLES wait states and an internal word array.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    r_write;
  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;
  logic                    r_req_ready;
  logic                    r_resp_valid;
  logic [31:0]             r_rdata;
  logic                    r_err;
  logic                    r_busy;
  logic [31:0]             r_mem [DEPTH];

  logic                    w_accept;
  logic                    w_do_access;
  logic                    w_acc_write;
  logic [31:0]             w_acc_addr;
  logic [31:0]             w_acc_wdata;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_err;

  // Zero-wait accesses use the request ports directly; otherwise the latched copy.
  assign w_acc_write = (r_state == S_IDLE) ? req_write : r_write;
  assign w_acc_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_idx       = w_acc_addr[ADDR_WIDTH+1:2];
  assign w_err       = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr[31:ADDR_WIDTH+2] != '0);

  // Next-state, wait counter and access strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_do_access = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_do_access = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_do_access = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, request latch and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_resp_valid <= (w_state_nxt == S_RESP);
      r_busy       <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_do_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_acc_write) ? 32'd0 : r_mem[w_idx];
      end else if ((r_state == S_RESP) && resp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  // Array commit: only on the edge entering RESP, never on a reset edge.
  always_ff @(posedge clk) begin
    if (!reset && w_do_access && w_acc_write && !w_err) begin
      r_mem[w_idx] <= w_acc_wdata;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of transactions against a WAIT_CYCLES=2
// instance with a response scoreboard, plus reset and zero-wait sequences.
module tb_dmem_responder;

  localparam int WAIT_A = 2;

  logic        clk = 1'b0;
  logic        reset;
  // Instance A (two wait states)
  logic        req_valid, req_write, req_ready, resp_valid, resp_ready, resp_err, busy;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  // Instance B (zero wait states)
  logic        b_req_valid, b_req_write, b_req_ready, b_resp_valid, b_resp_err, b_busy;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  vec_t vecs[12];
  exp_t sb_q[$];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(WAIT_A)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_ready(b_req_ready), .resp_valid(b_resp_valid), .resp_ready(1'b1),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".req_ready"},  32'(req_ready),  32'd1);
    chk({name, ".resp_valid"}, 32'(resp_valid), 32'd0);
    chk({name, ".busy"},       32'(busy),       32'd0);
    chk({name, ".rdata"},      resp_rdata,      32'd0);
    chk({name, ".err"},        32'(resp_err),   32'd0);
  endtask

  // One full transaction on instance A; expected response goes through the scoreboard.
  task automatic txn(input vec_t v);
    int   n;
    exp_t e;
    sb_q.push_back('{err: v.exp_err, rdata: v.exp_rdata});
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = v.w;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    resp_ready = (v.hold == 0);
    @(posedge clk); #1;
    chk("accept.busy", 32'(busy), 32'd1);
    // Scramble request ports: the responder must use its latched copy.
    req_valid = 1'b0;
    req_write = ~v.w;
    req_addr  = ~v.addr;
    req_wdata = ~v.wdata;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(WAIT_A));
    if (sb_q.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("resp.rdata", resp_rdata, e.rdata);
      chk("resp.err", 32'(resp_err), 32'(e.err));
      chk("resp.req_ready", 32'(req_ready), 32'd0);
      for (int i = 0; i < v.hold; i++) begin
        // Offer a store to 0x10 that must be ignored while responding.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        @(posedge clk); #1;
        chk("hold.resp_valid", 32'(resp_valid), 32'd1);
        chk("hold.rdata", resp_rdata, e.rdata);
        chk("hold.busy", 32'(busy), 32'd1);
        chk("hold.req_ready", 32'(req_ready), 32'd0);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk_idle("done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0014, 32'hCAFE_F00D, 0, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0014, 32'h0,         5, 32'hCAFE_F00D, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0012, 32'h5555_5555, 0, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_1000, 32'h0,         0, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b1, 32'h0000_0020, 32'h1111_1111, 0, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 0, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         0, 32'hA5A5_A5A5, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0011, 32'h0,         0, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         0, 32'h0000_0000, 1'b1};

    reset       = 1'b1;
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_addr    = 32'h10;
    req_wdata   = 32'h0;
    resp_ready  = 1'b1;
    b_req_valid = 1'b0;
    b_req_write = 1'b0;
    b_req_addr  = 32'h0;
    b_req_wdata = 32'h0;

    // Reset held two cycles with a request pending: nothing accepted.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_idle("reset");
    end
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk_idle("post_reset");

    for (int i = 0; i < 12; i++) begin
      txn(vecs[i]);
    end

    // Reset landing on the commit edge discards the store.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst.busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_idle("midrst");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst.no_resp", 32'(resp_valid), 32'd0);
    end
    txn('{1'b0, 32'h0000_0020, 32'h0, 0, 32'h1111_1111, 1'b0});

    // Zero-wait instance: store then loads, request held high, one accept per 2 cycles.
    @(negedge clk);
    b_req_valid = 1'b1;
    b_req_write = 1'b1;
    b_req_addr  = 32'h40;
    b_req_wdata = 32'h0BAD_C0DE;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("w0.resp_valid", 32'(b_resp_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("w0.req_ready", 32'(b_req_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("w0.busy", 32'(b_busy), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k == 0) begin
        chk("w0.store_rdata", b_resp_rdata, 32'd0);
        b_req_write = 1'b0;
      end else if (k % 2 == 0) begin
        chk("w0.load_rdata", b_resp_rdata, 32'h0BAD_C0DE);
        chk("w0.load_err", 32'(b_resp_err), 32'd0);
      end
    end
    b_req_valid = 1'b0;

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
